// File: rtl/linebuffer_pkg.sv
// linebuffer_pkg
//   Shared types and helpers for the ping-pong line buffer.
//   - rp_state_t : replay FSM states
//   - out_kind_t : what the output register shows one stage later
//   - SLOT_SHIFT : bit offset of the slot code inside the marker pixel
//   - FETCH_LEAD : cycles between the FSM entering a phase and that phase
//                  appearing on de/rgb_out (RAM read + output register)
//   - target_sel : picks the target-width index from a line width
package linebuffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LEFT,
        ST_PIX,
        ST_RIGHT,
        ST_MARK
    } rp_state_t;

    typedef enum logic [1:0] {
        OUT_NONE,
        OUT_BLACK,
        OUT_PIX,
        OUT_MARK
    } out_kind_t;

    localparam int SLOT_SHIFT = 13;
    localparam int FETCH_LEAD = 2;

    // 0 -> first target, 1 -> second, 2 -> third
    function automatic logic [1:0] target_sel(input int width, input int thr0, input int thr1);
        if (width < thr0)
            return 2'd0;
        else if (width < thr1)
            return 2'd1;
        else
            return 2'd2;
    endfunction

endpackage

// File: rtl/linebuffer_ram.sv
// linebuffer_ram
//   Simple dual-port RAM, one bank of the ping-pong buffer.
//   Ports:
//     clk_vid : clock
//     we      : write enable
//     waddr   : write address
//     wdata   : write data
//     raddr   : read address
//     rdata   : registered read data (1-cycle latency)
module linebuffer_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_vid,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk_vid) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/linebuffer_pingpong.sv
// linebuffer_pingpong
//   Captures each video line into one RAM bank while replaying the previous
//   line from the other bank, centred in a selectable target width and
//   followed by a one-cycle slot marker.
//   Ports:
//     clk_vid, reset          : clock, synchronous active-high reset
//     vsync_in, hsync_in      : core sync levels
//     ce_pix, disable_pix     : pixel strobe and write suppression
//     rgb_in                  : pixel data
//     vsync_out, hsync_out    : one-cycle sync pulses
//     de, rgb_out             : replay data enable and pixel / marker
//     line_width, overflow    : status of the line being replayed
//
//   The replay FSM runs FETCH_LEAD cycles ahead of the outputs: in the cycle
//   a PIX state is held its address is presented to the RAM, the data comes
//   back next cycle and is registered onto rgb_out the cycle after.
module linebuffer_pingpong
    import linebuffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 10,
    parameter int HS_DELAY    = 15,
    parameter int HS_PULSE_AT = 6,
    parameter int TGT0        = 256,
    parameter int TGT1        = 360,
    parameter int TGT2        = 512,
    parameter int THR0        = 280,
    parameter int THR1        = 380,
    parameter int SLOT0       = 0,
    parameter int SLOT1       = 2,
    parameter int SLOT2       = 4
) (
    input  logic                  clk_vid,
    input  logic                  reset,
    input  logic                  vsync_in,
    input  logic                  hsync_in,
    input  logic                  ce_pix,
    input  logic                  disable_pix,
    input  logic [DATA_WIDTH-1:0] rgb_in,
    output logic                  vsync_out,
    output logic                  hsync_out,
    output logic                  de,
    output logic [DATA_WIDTH-1:0] rgb_out,
    output logic [ADDR_WIDTH:0]   line_width,
    output logic                  overflow
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam int CW = 16;

    logic                  hs_prev, vs_prev;
    logic                  hs_rise;
    logic                  wr_bank;
    logic [LW-1:0]         wr_addr;
    logic                  wr_ovf;
    logic                  pix_stb, wr_full, wr_en, wr_bank_eff;
    logic [ADDR_WIDTH-1:0] wr_ram_addr;
    logic [CW-1:0]         hs_cnt;
    rp_state_t             state;
    out_kind_t             cur_kind, p1_kind;
    logic [CW-1:0]         ph_cnt;
    logic [LW-1:0]         rd_idx;
    logic [1:0][DATA_WIDTH-1:0] bank_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [1:0]            sel;
    logic [CW-1:0]         tgt, diff, left_n, right_n;
    logic [3:0]            slot;

    assign hs_rise = hsync_in & ~hs_prev;
    assign pix_stb = ce_pix & ~disable_pix;

    // A strobe coinciding with the hsync edge is pixel 0 of the new line,
    // written to the bank that is about to become the write bank.
    assign wr_bank_eff = hs_rise ? ~wr_bank : wr_bank;
    assign wr_ram_addr = hs_rise ? '0 : wr_addr[ADDR_WIDTH-1:0];
    assign wr_full     = hs_rise ? 1'b0 : wr_addr[ADDR_WIDTH];
    assign wr_en       = pix_stb & ~wr_full;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        linebuffer_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ram (
            .clk_vid(clk_vid),
            .we     (wr_en & (wr_bank_eff == 1'(b))),
            .waddr  (wr_ram_addr),
            .wdata  (rgb_in),
            .raddr  (rd_idx[ADDR_WIDTH-1:0]),
            .rdata  (bank_q[b])
        );
    end

    assign rd_q = bank_q[~wr_bank];

    // Target width, slot and border split for the latched line
    always_comb begin
        sel = target_sel(int'(line_width), THR0, THR1);
        case (sel)
            2'd0:    begin tgt = CW'(TGT0); slot = 4'(SLOT0); end
            2'd1:    begin tgt = CW'(TGT1); slot = 4'(SLOT1); end
            default: begin tgt = CW'(TGT2); slot = 4'(SLOT2); end
        endcase
        diff    = (tgt > CW'(line_width)) ? tgt - CW'(line_width) : '0;
        left_n  = diff >> 1;
        right_n = diff - left_n;
    end

    always_comb begin
        cur_kind = OUT_NONE;
        case (state)
            ST_LEFT, ST_RIGHT: cur_kind = OUT_BLACK;
            ST_PIX:            cur_kind = OUT_PIX;
            ST_MARK:           cur_kind = OUT_MARK;
            default:           cur_kind = OUT_NONE;
        endcase
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            hs_prev    <= 1'b0;
            vs_prev    <= 1'b0;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            wr_bank    <= 1'b0;
            wr_addr    <= '0;
            wr_ovf     <= 1'b0;
            line_width <= '0;
            overflow   <= 1'b0;
            hs_cnt     <= '0;
            state      <= ST_IDLE;
            ph_cnt     <= '0;
            rd_idx     <= '0;
            p1_kind    <= OUT_NONE;
            de         <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hs_prev   <= hsync_in;
            vs_prev   <= vsync_in;
            vsync_out <= vsync_in & ~vs_prev;

            // write side
            if (hs_rise) begin
                wr_bank    <= ~wr_bank;
                line_width <= wr_addr;
                overflow   <= wr_ovf;
                wr_addr    <= LW'(wr_en);
                wr_ovf     <= 1'b0;
            end else begin
                if (wr_en)
                    wr_addr <= wr_addr + LW'(1);
                if (pix_stb & wr_full)
                    wr_ovf <= 1'b1;
            end

            // hsync delay counter; keeps running after the FSM leaves WAIT
            if (hs_rise)
                hs_cnt <= CW'(HS_DELAY);
            else if (hs_cnt != '0)
                hs_cnt <= hs_cnt - CW'(1);

            if (HS_PULSE_AT == 0)
                hsync_out <= hs_rise;
            else
                hsync_out <= ~hs_rise && (hs_cnt == CW'(HS_DELAY - HS_PULSE_AT + 1));

            // replay
            if (hs_rise) begin
                state   <= ST_WAIT;
                ph_cnt  <= '0;
                rd_idx  <= '0;
                p1_kind <= OUT_NONE;
                de      <= 1'b0;
                rgb_out <= '0;
            end else begin
                p1_kind <= cur_kind;
                de      <= (p1_kind == OUT_BLACK) || (p1_kind == OUT_PIX);
                case (p1_kind)
                    OUT_PIX:  rgb_out <= rd_q;
                    OUT_MARK: rgb_out <= DATA_WIDTH'(slot) << SLOT_SHIFT;
                    default:  rgb_out <= '0;
                endcase

                case (state)
                    ST_WAIT: begin
                        // leave early by the pipeline lead so the first de
                        // lands HS_DELAY+1 cycles after the edge
                        if (hs_cnt <= CW'(FETCH_LEAD)) begin
                            ph_cnt <= '0;
                            rd_idx <= '0;
                            if (line_width == '0)
                                state <= ST_IDLE;
                            else if (left_n != '0)
                                state <= ST_LEFT;
                            else
                                state <= ST_PIX;
                        end
                    end
                    ST_LEFT: begin
                        if (ph_cnt == left_n - CW'(1)) begin
                            ph_cnt <= '0;
                            state  <= ST_PIX;
                        end else begin
                            ph_cnt <= ph_cnt + CW'(1);
                        end
                    end
                    ST_PIX: begin
                        if (rd_idx == line_width - LW'(1))
                            state <= (right_n != '0) ? ST_RIGHT : ST_MARK;
                        else
                            rd_idx <= rd_idx + LW'(1);
                    end
                    ST_RIGHT: begin
                        if (ph_cnt == right_n - CW'(1)) begin
                            ph_cnt <= '0;
                            state  <= ST_MARK;
                        end else begin
                            ph_cnt <= ph_cnt + CW'(1);
                        end
                    end
                    ST_MARK: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_linebuffer_pingpong.sv
module tb_linebuffer_pingpong;

    localparam int DW  = 24;
    localparam int AW  = 10;
    localparam int HSD = 15;
    localparam int HSP = 6;
    localparam int NV  = 10;

    logic          clk_vid = 1'b0;
    logic          reset, vsync_in, hsync_in, ce_pix, disable_pix;
    logic [DW-1:0] rgb_in;
    logic          vsync_out, hsync_out, de, overflow;
    logic [DW-1:0] rgb_out;
    logic [AW:0]   line_width;

    int total = 0;
    int bad   = 0;

    always #5 clk_vid = ~clk_vid;

    linebuffer_pingpong dut (
        .clk_vid    (clk_vid),
        .reset      (reset),
        .vsync_in   (vsync_in),
        .hsync_in   (hsync_in),
        .ce_pix     (ce_pix),
        .disable_pix(disable_pix),
        .rgb_in     (rgb_in),
        .vsync_out  (vsync_out),
        .hsync_out  (hsync_out),
        .de         (de),
        .rgb_out    (rgb_out),
        .line_width (line_width),
        .overflow   (overflow)
    );

    // n_strobe pixel strobes; with step 2 every odd strobe is disabled, so
    // stored pixel k carries strobe number k*step in its low 16 bits.
    typedef struct {
        int          n_strobe;
        int          step;
        logic [7:0]  seed;
        int          exp_w;
        logic        exp_ovf;
        int          exp_left;
        int          exp_right;
        logic [23:0] exp_mark;
    } vec_t;

    vec_t vecs [NV];
    vec_t v_zero, v_b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic write_line(input int n, input int step, input logic [7:0] seed);
        for (int s = 0; s < n; s++) begin
            @(negedge clk_vid);
            ce_pix      = 1'b1;
            disable_pix = (step == 2) && (s % 2 == 1);
            rgb_in      = {seed, 16'(s)};
        end
        @(negedge clk_vid);
        ce_pix      = 1'b0;
        disable_pix = 1'b0;
    endtask

    // Called right after hsync_in was raised on a negedge; off=0 is the
    // cycle following the edge that samples it.
    task automatic check_line(input int id, input vec_t v);
        int          tot, first, idx;
        int          de_bad, rgb_bad, hs_bad, de_cnt;
        logic        exp_de;
        logic [23:0] exp_rgb, mark_seen;
        tot     = v.exp_left + v.exp_w + v.exp_right;
        first   = HSD + 1;
        de_bad  = 0;
        rgb_bad = 0;
        hs_bad  = 0;
        de_cnt  = 0;
        mark_seen = '0;
        for (int off = 0; off < first + tot + 4; off++) begin
            @(negedge clk_vid);
            if (off == 0) begin
                check($sformatf("line%0d width", id), 32'(line_width), 32'(v.exp_w));
                check($sformatf("line%0d overflow", id), 32'(overflow), 32'(v.exp_ovf));
            end
            if (off == 3)
                hsync_in = 1'b0;
            exp_de  = (v.exp_w != 0) && (off >= first) && (off < first + tot);
            exp_rgb = '0;
            if (exp_de) begin
                idx = off - first;
                if (idx >= v.exp_left && idx < v.exp_left + v.exp_w)
                    exp_rgb = {v.seed, 16'((idx - v.exp_left) * v.step)};
            end else if (v.exp_w != 0 && off == first + tot) begin
                exp_rgb   = v.exp_mark;
                mark_seen = rgb_out;
            end
            if (de !== exp_de)  de_bad++;
            if (rgb_out !== exp_rgb) rgb_bad++;
            if (hsync_out !== (off == HSP)) hs_bad++;
            if (de === 1'b1) de_cnt++;
        end
        check($sformatf("line%0d de pattern errors", id), 32'(de_bad), 0);
        check($sformatf("line%0d rgb pattern errors", id), 32'(rgb_bad), 0);
        check($sformatf("line%0d hsync_out errors", id), 32'(hs_bad), 0);
        check($sformatf("line%0d de count", id), 32'(de_cnt), 32'(tot));
        if (v.exp_w != 0)
            check($sformatf("line%0d marker", id), 32'(mark_seen), 32'(v.exp_mark));
    endtask

    initial begin
        reset = 1'b1; vsync_in = 1'b0; hsync_in = 1'b0;
        ce_pix = 1'b0; disable_pix = 1'b0; rgb_in = '0;

        vecs[0] = '{256,  1, 8'h10, 256,  1'b0, 0,   0,   24'h000000};
        vecs[1] = '{300,  1, 8'h11, 300,  1'b0, 30,  30,  24'h004000};
        vecs[2] = '{301,  1, 8'h12, 301,  1'b0, 29,  30,  24'h004000};
        vecs[3] = '{1100, 1, 8'h13, 1024, 1'b1, 0,   0,   24'h008000};
        vecs[4] = '{200,  1, 8'h14, 200,  1'b0, 28,  28,  24'h000000};
        vecs[5] = '{512,  2, 8'h15, 256,  1'b0, 0,   0,   24'h000000};
        vecs[6] = '{379,  1, 8'h16, 379,  1'b0, 0,   0,   24'h004000};
        vecs[7] = '{380,  1, 8'h17, 380,  1'b0, 66,  66,  24'h008000};
        vecs[8] = '{1,    1, 8'h18, 1,    1'b0, 127, 128, 24'h000000};
        vecs[9] = '{280,  1, 8'h19, 280,  1'b0, 40,  40,  24'h004000};
        v_zero  = '{0,    1, 8'h00, 0,    1'b0, 0,   0,   24'h000000};
        v_b0    = '{256,  1, 8'hB0, 256,  1'b0, 0,   0,   24'h000000};

        // reset state
        repeat (3) @(negedge clk_vid);
        check("reset de", 32'(de), 0);
        check("reset rgb_out", 32'(rgb_out), 0);
        check("reset hsync_out", 32'(hsync_out), 0);
        check("reset vsync_out", 32'(vsync_out), 0);
        check("reset line_width", 32'(line_width), 0);
        check("reset overflow", 32'(overflow), 0);
        reset = 1'b0;

        // vsync pulse on rising edge only
        @(negedge clk_vid);
        vsync_in = 1'b1;
        @(negedge clk_vid);
        check("vsync pulse", 32'(vsync_out), 1);
        @(negedge clk_vid);
        check("vsync single cycle", 32'(vsync_out), 0);
        vsync_in = 1'b0;

        // table: each line replays while the next is written
        write_line(vecs[0].n_strobe, vecs[0].step, vecs[0].seed);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_vid);
            hsync_in = 1'b1;
            fork
                check_line(i, vecs[i]);
                begin
                    if (i + 1 < NV)
                        write_line(vecs[i+1].n_strobe, vecs[i+1].step, vecs[i+1].seed);
                end
            join
        end

        // reset in the middle of a replay
        write_line(200, 1, 8'hA0);
        @(negedge clk_vid);
        hsync_in = 1'b1;
        repeat (3) @(negedge clk_vid);
        hsync_in = 1'b0;
        repeat (HSD + 50) @(negedge clk_vid);
        check("de before reset", 32'(de), 1);
        reset = 1'b1;
        @(negedge clk_vid);
        check("de after reset", 32'(de), 0);
        check("rgb after reset", 32'(rgb_out), 0);
        check("width after reset", 32'(line_width), 0);
        reset = 1'b0;

        // first hsync after reset: nothing to replay
        @(negedge clk_vid);
        hsync_in = 1'b1;
        fork
            check_line(20, v_zero);
            write_line(256, 1, 8'hB0);
        join
        @(negedge clk_vid);
        hsync_in = 1'b1;
        fork
            check_line(21, v_b0);
            write_line(100, 1, 8'hC0);
        join

        // hsync during replay aborts it
        @(negedge clk_vid);
        hsync_in = 1'b1;
        repeat (3) @(negedge clk_vid);
        hsync_in = 1'b0;
        repeat (HSD + 20) @(negedge clk_vid);
        check("de before abort", 32'(de), 1);
        hsync_in = 1'b1;
        check_line(22, v_zero);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
